hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard/stall controller for the 5-stage MIPS core with BEQ resolved in ID and MEM→ID forwarding.
- Drives the write-inhibit end of the PC interface (`nWrite`, active-low), the IF/ID hold and flush, and ID/EX bubble insertion.
- Multi-cycle stalls use an explicit FSM plus down-counter; stalls are not re-derived combinationally each cycle.

Parameters:
- REG_W, 5, register-address width
- CNT_W, 2, stall down-counter width; must hold the maximum stall of 2
- PERF_W, 32, stall performance counter width (optional feature only)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- idRs  in  REG_W  ID-stage rs
- idRt  in  REG_W  ID-stage rt
- idUseRs  in  1  ID instruction reads rs
- idUseRt  in  1  ID instruction reads rt
- idBranch  in  1  ID instruction is BEQ
- idJump  in  1  ID instruction is J
- branchTaken  in  1  ID comparator result, valid when idBranch=1
- exRegWrite  in  1  EX instruction writes a register
- exMemRead  in  1  EX instruction is a load
- exDst  in  REG_W  EX destination register
- memMemRead  in  1  MEM instruction is a load
- memDst  in  REG_W  MEM destination register
- dmemBusy  in  1  data memory not ready; freeze the whole pipeline
- pcNWrite  out  1  to the pc `nWrite` port; 1 = hold PC
- ifidNWrite  out  1  1 = hold the IF/ID register
- ifidFlush  out  1  1 = squash the IF/ID contents next edge
- idexFlush  out  1  1 = load a bubble into ID/EX
- freeze  out  1  1 = hold ID/EX, EX/MEM and MEM/WB
- stalling  out  1  1 while in state STALL

Behaviour:
- Match definitions:
  - matchEx = exRegWrite & exDst≠0 & ((idUseRs & exDst==idRs) | (idUseRt & exDst==idRt))
  - matchMemLd = memMemRead & memDst≠0 & the same rs/rt comparison against memDst
- Required stall count N in RUN:
  - idBranch & exMemRead & matchEx → N=2
  - else idBranch & matchEx → N=1
  - else idBranch & matchMemLd → N=1
  - else exMemRead & matchEx (load-use) → N=1
  - else N=0
- Register 0 never causes a stall.
- FSM states: RUN, STALL. Counter cnt is CNT_W bits.
- Priority 1, dmemBusy=1, any state:
  - freeze=1, pcNWrite=1, ifidNWrite=1, idexFlush=0, ifidFlush=0
  - state and cnt hold
- RUN, N≥1:
  - pcNWrite=1, ifidNWrite=1, idexFlush=1, ifidFlush=0 in the same cycle
  - if N=2: next state STALL, cnt←1; else stay in RUN
- RUN, N=0:
  - pcNWrite=0, ifidNWrite=0, idexFlush=0
  - ifidFlush = idJump | (idBranch & branchTaken)
- STALL:
  - pcNWrite=1, ifidNWrite=1, idexFlush=1, ifidFlush=0, stalling=1
  - cnt←cnt−1; when cnt==1, next state RUN
  - inputs are not re-evaluated while in STALL
- A taken branch or jump never flushes during a stall cycle. It flushes on the first non-stall cycle.
- Reset, including mid-stall:
  - state←RUN, cnt←0
  - all outputs are 0 on the cycle reset is sampled high: PC writes enabled, no flushes, freeze=0
- Outputs are combinational from state and inputs. State and cnt are registered.

Optional Feature:
- Macro: HAZARD_PERF_EN
- Defined:
  - adds output stallCycles (PERF_W) and output flushCount (PERF_W)
  - stallCycles increments on every cycle with pcNWrite=1 & freeze=0
  - flushCount increments on every cycle with ifidFlush=1
  - both counters wrap modulo 2^PERF_W and clear on reset
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package hazard_pkg:
  - state encoding: RUN=1'b0, STALL=1'b1
  - stall-count constants: STALL_LOAD_BEQ=2, STALL_ONE=1
  - REG_W default
- One natural sub-module, hazard_match: the combinational rs/rt-versus-dst comparator. Instantiate it twice, for EX and MEM.

Test Plan:
- Load-use: EX `lw $8`, ID `add` using $8 (exMemRead=1, exDst=8, idRs=8) → one cycle with pcNWrite=1, ifidNWrite=1, idexFlush=1; next cycle all 0.
- BEQ after load: EX `lw $9`, ID `beq $9,$0` → two consecutive stall cycles (stalling=1 on the second); third cycle pcNWrite=0.
- BEQ after ALU: EX writes $10, ID `beq $10` → one stall cycle. Separately, MEM load of $10 with no EX match → one stall cycle.
- Register 0: exDst=0, exMemRead=1, idRs=0 → no stall. Jump in ID → ifidFlush=1 for one cycle, pcNWrite=0.
- Busy during stall: enter STALL, then dmemBusy=1 for 3 cycles → freeze=1, idexFlush=0, state held at STALL; after release, one remaining stall cycle, then RUN.
- Reset mid-stall: reset=1 while stalling=1 → next cycle state RUN, all outputs 0. With HAZARD_PERF_EN defined, stallCycles=0 after reset.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
package hazard_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam int STALL_LOAD_BEQ = 2;
    localparam int STALL_ONE      = 1;
    localparam int REG_W_DEF      = 5;

endpackage

// File: rtl/hazard_match.sv
// Compares the ID-stage source registers against one later-stage destination.
module hazard_match #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             useRs,
    input  logic             useRt,
    input  logic             wrEn,
    input  logic [REG_W-1:0] dst,
    output logic             hit
);

    logic dstNonZero;

    // $0 is hard-wired, so a write to it can never create a dependency
    assign dstNonZero = (dst != '0);
    assign hit = wrEn && dstNonZero &&
                 ((useRs && (dst == rs)) || (useRt && (dst == rt)));

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage core (BEQ in ID, MEM->ID forwarding).
// Optional stall/flush performance counters when HAZARD_PERF_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int CNT_W = 2
`ifdef HAZARD_PERF_EN
    ,
    parameter int PERF_W = 32
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] idRs,
    input  logic [REG_W-1:0] idRt,
    input  logic             idUseRs,
    input  logic             idUseRt,
    input  logic             idBranch,
    input  logic             idJump,
    input  logic             branchTaken,
    input  logic             exRegWrite,
    input  logic             exMemRead,
    input  logic [REG_W-1:0] exDst,
    input  logic             memMemRead,
    input  logic [REG_W-1:0] memDst,
    input  logic             dmemBusy,
    output logic             pcNWrite,
    output logic             ifidNWrite,
    output logic             ifidFlush,
    output logic             idexFlush,
    output logic             freeze,
    output logic             stalling
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] stallCycles,
    output logic [PERF_W-1:0] flushCount
`endif
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] need;
    logic             matchEx;
    logic             matchMemLd;

    hazard_match #(
        .REG_W (REG_W)
    ) u_match_ex (
        .rs    (idRs),
        .rt    (idRt),
        .useRs (idUseRs),
        .useRt (idUseRt),
        .wrEn  (exRegWrite),
        .dst   (exDst),
        .hit   (matchEx)
    );

    hazard_match #(
        .REG_W (REG_W)
    ) u_match_mem (
        .rs    (idRs),
        .rt    (idRt),
        .useRs (idUseRs),
        .useRt (idUseRt),
        .wrEn  (memMemRead),
        .dst   (memDst),
        .hit   (matchMemLd)
    );

    // Stall length demanded by the instruction pair currently in ID/EX/MEM
    always_comb begin
        need = '0;
        if (idBranch && exMemRead && matchEx) begin
            need = CNT_W'(STALL_LOAD_BEQ);
        end else if (idBranch && (matchEx || matchMemLd)) begin
            need = CNT_W'(STALL_ONE);
        end else if (exMemRead && matchEx) begin
            need = CNT_W'(STALL_ONE);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pcNWrite   = 1'b0;
        ifidNWrite = 1'b0;
        ifidFlush  = 1'b0;
        idexFlush  = 1'b0;
        freeze     = 1'b0;
        stalling   = (state_q == STALL);

        if (dmemBusy) begin
            freeze     = 1'b1;
            pcNWrite   = 1'b1;
            ifidNWrite = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (need != '0) begin
                        pcNWrite   = 1'b1;
                        ifidNWrite = 1'b1;
                        idexFlush  = 1'b1;
                        // First stall cycle happens here; STALL covers the rest
                        if (need == CNT_W'(STALL_LOAD_BEQ)) begin
                            state_d = STALL;
                            cnt_d   = CNT_W'(STALL_LOAD_BEQ - 1);
                        end
                    end else begin
                        ifidFlush = idJump || (idBranch && branchTaken);
                    end
                end
                STALL: begin
                    pcNWrite   = 1'b1;
                    ifidNWrite = 1'b1;
                    idexFlush  = 1'b1;
                    cnt_d      = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end

        // The pipeline restarts cleanly: nothing held or squashed during reset
        if (reset) begin
            pcNWrite   = 1'b0;
            ifidNWrite = 1'b0;
            ifidFlush  = 1'b0;
            idexFlush  = 1'b0;
            freeze     = 1'b0;
            stalling   = 1'b0;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stallCycles <= '0;
            flushCount  <= '0;
        end else begin
            if (pcNWrite && !freeze) begin
                stallCycles <= stallCycles + PERF_W'(1);
            end
            if (ifidFlush) begin
                flushCount <= flushCount + PERF_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected output vectors queued per cycle.
module tb_hazard_ctrl;

    localparam int REG_W = 5;

    logic             clock = 1'b0;
    logic             reset;
    logic [REG_W-1:0] idRs, idRt, exDst, memDst;
    logic             idUseRs, idUseRt, idBranch, idJump, branchTaken;
    logic             exRegWrite, exMemRead, memMemRead, dmemBusy;
    logic             pcNWrite, ifidNWrite, ifidFlush, idexFlush, freeze, stalling;
`ifdef HAZARD_PERF_EN
    logic [31:0]      stallCycles, flushCount;
`endif

    int compared = 0;
    int mismatched = 0;
    logic [5:0] sb[$];
    logic [5:0] got, exp;

    // Output vector order: {pcNWrite, ifidNWrite, ifidFlush, idexFlush, freeze, stalling}
    localparam logic [5:0] O_IDLE  = 6'b000000;
    localparam logic [5:0] O_STALL = 6'b110100;
    localparam logic [5:0] O_ST2   = 6'b110101;
    localparam logic [5:0] O_FLUSH = 6'b001000;
    localparam logic [5:0] O_BUSY  = 6'b110010;
    localparam logic [5:0] O_BUSYS = 6'b110011;

    hazard_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .idRs        (idRs),
        .idRt        (idRt),
        .idUseRs     (idUseRs),
        .idUseRt     (idUseRt),
        .idBranch    (idBranch),
        .idJump      (idJump),
        .branchTaken (branchTaken),
        .exRegWrite  (exRegWrite),
        .exMemRead   (exMemRead),
        .exDst       (exDst),
        .memMemRead  (memMemRead),
        .memDst      (memDst),
        .dmemBusy    (dmemBusy),
        .pcNWrite    (pcNWrite),
        .ifidNWrite  (ifidNWrite),
        .ifidFlush   (ifidFlush),
        .idexFlush   (idexFlush),
        .freeze      (freeze),
        .stalling    (stalling)
`ifdef HAZARD_PERF_EN
        ,
        .stallCycles (stallCycles),
        .flushCount  (flushCount)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [5:0] outs();
        return {pcNWrite, ifidNWrite, ifidFlush, idexFlush, freeze, stalling};
    endfunction

    task automatic idle();
        idRs = '0; idRt = '0; exDst = '0; memDst = '0;
        idUseRs = 0; idUseRt = 0; idBranch = 0; idJump = 0; branchTaken = 0;
        exRegWrite = 0; exMemRead = 0; memMemRead = 0; dmemBusy = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // EX: lw rd ; ID: instruction reading rs=rd
    task automatic set_load_use(input logic [REG_W-1:0] rd, input logic br);
        idle();
        exRegWrite = 1; exMemRead = 1; exDst = rd;
        idUseRs = 1; idRs = rd; idUseRt = 1; idRt = 5'd0; idBranch = br;
    endtask

    task automatic test_reset();
        reset = 1;
        idle();
        sb.push_back(O_IDLE);
        @(negedge clock);
        got = outs(); exp = sb.pop_front(); compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL reset_hold: got %b expected %b", got, exp);
        end
        tick();
        reset = 0;
        sb.push_back(O_IDLE);
        @(negedge clock);
        got = outs(); exp = sb.pop_front(); compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL reset_release: got %b expected %b", got, exp);
        end
        tick();
    endtask

    task automatic test_load_use();
        set_load_use(5'd8, 1'b0);
        sb.push_back(O_STALL);
        @(negedge clock);
        got = outs(); exp = sb.pop_front(); compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL load_use_stall: got %b expected %b", got, exp);
        end
        tick();
        // Load has moved to MEM; non-branch consumer is served by forwarding
        idle(); memMemRead = 1; memDst = 5'd8; idUseRs = 1; idRs = 5'd8;
        sb.push_back(O_IDLE);
        @(negedge clock);
        got = outs(); exp = sb.pop_front(); compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL load_use_resume: got %b expected %b", got, exp);
        end
        tick();
    endtask

    task automatic test_beq_after_load();
        set_load_use(5'd9, 1'b1);
        branchTaken = 1;
        sb.push_back(O_STALL);
        sb.push_back(O_ST2);
        sb.push_back(O_FLUSH);
        sb.push_back(O_IDLE);
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                // Inputs are ignored in STALL; a jump here must not flush
                idle(); idJump = 1;
            end
            if (c == 2) begin
                idle(); idBranch = 1; branchTaken = 1; idUseRs = 1; idRs = 5'd9;
            end
            if (c == 3) idle();
            @(negedge clock);
            got = outs(); exp = sb.pop_front(); compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL beq_load_cycle%0d: got %b expected %b", c, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_beq_after_alu();
        for (int k = 0; k < 2; k++) begin
            idle(); idBranch = 1;
            if (k == 0) begin
                exRegWrite = 1; exDst = 5'd10; idUseRs = 1; idRs = 5'd10;
            end else begin
                memMemRead = 1; memDst = 5'd10; idUseRt = 1; idRt = 5'd10;
                exRegWrite = 1; exDst = 5'd11;
            end
            sb.push_back(O_STALL);
            sb.push_back(O_IDLE);
            @(negedge clock);
            got = outs(); exp = sb.pop_front(); compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL beq_alu%0d_stall: got %b expected %b", k, got, exp);
            end
            tick();
            idle(); idBranch = 1; branchTaken = 0; idUseRs = 1; idRs = 5'd10;
            @(negedge clock);
            got = outs(); exp = sb.pop_front(); compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL beq_alu%0d_resume: got %b expected %b", k, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_reg0_and_jump();
        set_load_use(5'd0, 1'b0);
        sb.push_back(O_IDLE);
        @(negedge clock);
        got = outs(); exp = sb.pop_front(); compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL reg0_load: got %b expected %b", got, exp);
        end
        tick();
        set_load_use(5'd0, 1'b1);
        sb.push_back(O_IDLE);
        @(negedge clock);
        got = outs(); exp = sb.pop_front(); compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL reg0_beq: got %b expected %b", got, exp);
        end
        tick();
        idle(); idJump = 1;
        sb.push_back(O_FLUSH);
        @(negedge clock);
        got = outs(); exp = sb.pop_front(); compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL jump_flush: got %b expected %b", got, exp);
        end
        tick();
    endtask

    task automatic test_busy_during_stall();
        // Busy in RUN with a pending hazard: freeze wins, no bubble
        set_load_use(5'd12, 1'b0);
        dmemBusy = 1;
        sb.push_back(O_BUSY);
        @(negedge clock);
        got = outs(); exp = sb.pop_front(); compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL busy_run: got %b expected %b", got, exp);
        end
        tick();
        set_load_use(5'd9, 1'b1);
        sb.push_back(O_STALL);
        for (int c = 0; c < 3; c++) sb.push_back(O_BUSYS);
        sb.push_back(O_ST2);
        sb.push_back(O_IDLE);
        for (int c = 0; c < 6; c++) begin
            if (c >= 1 && c <= 3) begin
                idle(); dmemBusy = 1;
            end
            if (c >= 4) idle();
            @(negedge clock);
            got = outs(); exp = sb.pop_front(); compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL busy_stall_cycle%0d: got %b expected %b", c, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_stall();
        set_load_use(5'd9, 1'b1);
        sb.push_back(O_STALL);
        sb.push_back(O_IDLE);
        sb.push_back(O_IDLE);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                idle(); reset = 1;
            end
            if (c == 2) reset = 0;
            @(negedge clock);
            got = outs(); exp = sb.pop_front(); compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL reset_mid_cycle%0d: got %b expected %b", c, got, exp);
            end
`ifdef HAZARD_PERF_EN
            if (c == 2) begin
                compared++;
                if (stallCycles !== 32'd0 || flushCount !== 32'd0) begin
                    mismatched++;
                    $display("FAIL perf_reset: got %0d/%0d expected 0/0",
                             stallCycles, flushCount);
                end
            end
`endif
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_beq_after_load();
        test_beq_after_alu();
        test_reg0_and_jump();
        test_busy_during_stall();
        test_reset_mid_stall();
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
